// File: rtl/prog_clock_divider.sv
// prog_clock_divider: multi-channel programmable clock divider / tick generator.
// Each channel emits a one-cycle tick and a 50% duty divided clock.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   en         global run enable; low freezes every channel
//   cfg_valid  divisor write request
//   cfg_ready  write accepted when cfg_valid & cfg_ready at posedge clk
//   cfg_ch     target channel of a write (CH_W bits)
//   cfg_div    new terminal count for the target channel (CNT_W bits)
//   tick       one-cycle pulse per channel at terminal count (NUM_CH bits)
//   clk_out    divided clock per channel (NUM_CH bits)
//   sync_clr   phase-align all channels (only with CLKDIV_SYNC_EN)
//
// Build option:
//   CLKDIV_SYNC_EN  when defined, adds sync_clr. A high sync_clr at posedge
//                   clears every counter, tick and clk_out and applies any
//                   pending divisor. When undefined, none of it exists.
//
// Tick period is div+1 cycles, clk_out period is 2*(div+1) cycles.
// New divisors are held in a shadow register and only take effect at a
// period boundary, so clk_out never produces a runt pulse.

module prog_clock_divider #(
    parameter  int CNT_W       = 28,
    parameter  int NUM_CH      = 2,
    parameter  int DEFAULT_DIV = 50000,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out
`ifdef CLKDIV_SYNC_EN
    ,
    input  logic              sync_clr
`endif
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

    logic              sync_w;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] wr_sel;

`ifdef CLKDIV_SYNC_EN
    assign sync_w = sync_clr;
`else
    assign sync_w = 1'b0;
`endif

    // Ready depends only on the addressed channel's pending flag.
    // Out-of-range channels select nothing: ready stays high and the
    // write is silently dropped.
    always_comb begin
        cfg_ready = 1'b1;
        wr_sel    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(cfg_ch) == i) begin
                cfg_ready = ~pending[i];
                wr_sel[i] = cfg_valid;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] div_q;
        logic [CNT_W-1:0] shadow_q;
        logic             pend_q;
        logic             tick_q;
        logic             clk_q;
        logic             at_tc;
        logic             at_start;
        logic             accept;
        logic             apply;

        assign at_tc    = (cnt_q == div_q);
        assign at_start = (cnt_q == '0);
        assign accept   = wr_sel[i] & ~pend_q;

        // A running channel swaps divisors on its terminal count. A frozen
        // channel may only swap while sitting at the start of a period,
        // which keeps cnt <= div for the equality compare.
        assign apply = pend_q & (sync_w | (en ? at_tc : at_start));

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q    <= '0;
                div_q    <= DIV_RST;
                shadow_q <= DIV_RST;
                pend_q   <= 1'b0;
                tick_q   <= 1'b0;
                clk_q    <= 1'b0;
            end else begin
                if (sync_w) begin
                    cnt_q  <= '0;
                    tick_q <= 1'b0;
                    clk_q  <= 1'b0;
                end else if (en && at_tc) begin
                    cnt_q  <= '0;
                    tick_q <= 1'b1;
                    clk_q  <= ~clk_q;
                end else if (en) begin
                    cnt_q  <= cnt_q + 1'b1;
                    tick_q <= 1'b0;
                end else begin
                    tick_q <= 1'b0;
                end

                // accept needs pend_q low and apply needs it high,
                // so the two never collide.
                if (apply) begin
                    div_q  <= shadow_q;
                    pend_q <= 1'b0;
                end
                if (accept) begin
                    shadow_q <= cfg_div;
                    pend_q   <= 1'b1;
                end
            end
        end

        assign pending[i] = pend_q;
        assign tick[i]    = tick_q;
        assign clk_out[i] = clk_q;
    end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Bench for prog_clock_divider (CNT_W=8, NUM_CH=2, DEFAULT_DIV=4),
// plus a 3-channel copy for the out-of-range channel write.

module tb_prog_clock_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         cfg_valid;
    logic         cfg_ch;
    logic [W-1:0] cfg_div;
    logic         cfg_ready;
    logic [1:0]   tick;
    logic [1:0]   clk_out;

    logic         valid3;
    logic [1:0]   ch3;
    logic [W-1:0] div3;
    logic         ready3;
    logic [2:0]   tick3;
    logic [2:0]   clk3;

`ifdef CLKDIV_SYNC_EN
    logic sync_clr = 1'b0;
`endif

    always #5 clk = ~clk;

    prog_clock_divider #(.CNT_W(W), .NUM_CH(2), .DEFAULT_DIV(4)) dut (
        .clk(clk), .reset(reset), .en(en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .tick(tick), .clk_out(clk_out)
`ifdef CLKDIV_SYNC_EN
        , .sync_clr(sync_clr)
`endif
    );

    prog_clock_divider #(.CNT_W(W), .NUM_CH(3), .DEFAULT_DIV(4)) dut3 (
        .clk(clk), .reset(reset), .en(en),
        .cfg_valid(valid3), .cfg_ready(ready3),
        .cfg_ch(ch3), .cfg_div(div3),
        .tick(tick3), .clk_out(clk3)
`ifdef CLKDIV_SYNC_EN
        , .sync_clr(1'b0)
`endif
    );

    typedef struct {
        logic         en;
        logic         valid;
        logic         ch;
        logic [W-1:0] div;
        logic         rdy;
        logic [1:0]   tk;
        logic [1:0]   co;
    } vec_t;

    typedef struct {
        string      name;
        logic [1:0] tk;
        logic [1:0] co;
    } exp_t;

    vec_t vecs[20];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input string name, input logic [1:0] tk,
                           input logic [1:0] co);
        exp_t e;
        e.name = name;
        e.tk   = tk;
        e.co   = co;
        sb.push_back(e);
    endtask

    task automatic sb_pop_chk();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got empty queue want entry");
        end else begin
            e = sb.pop_front();
            chk({e.name, " tick"}, 32'(tick), 32'(e.tk));
            chk({e.name, " clk_out"}, 32'(clk_out), 32'(e.co));
        end
    endtask

    task automatic wait_tick(input int ch, input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (tick[ch] !== 1'b1 && n < max);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int   n;
        int   stalls;
        logic c;
        logic [1:0] held;

        // en, valid, ch, div, ready, tick{1,0}, clk_out{1,0}
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 8'd1, 1'b1, 2'b00, 2'b00};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 8'd1, 1'b1, 2'b00, 2'b00};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 8'd1, 1'b1, 2'b00, 2'b00};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 8'd1, 1'b1, 2'b00, 2'b00};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 8'd1, 1'b1, 2'b11, 2'b11};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 8'd1, 1'b1, 2'b00, 2'b11};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 8'd1, 1'b1, 2'b00, 2'b11};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 8'd1, 1'b1, 2'b00, 2'b11};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 8'd1, 1'b0, 2'b00, 2'b11};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 8'd1, 1'b0, 2'b11, 2'b00};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 8'd1, 1'b1, 2'b00, 2'b00};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 8'd1, 1'b1, 2'b10, 2'b10};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 8'd1, 1'b1, 2'b00, 2'b10};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 8'd1, 1'b1, 2'b10, 2'b00};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 8'd1, 1'b1, 2'b01, 2'b01};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 8'd1, 1'b1, 2'b10, 2'b11};
        vecs[16] = '{1'b1, 1'b0, 1'b1, 8'd1, 1'b1, 2'b00, 2'b11};
        vecs[17] = '{1'b1, 1'b0, 1'b1, 8'd1, 1'b1, 2'b10, 2'b01};
        vecs[18] = '{1'b1, 1'b0, 1'b1, 8'd1, 1'b1, 2'b00, 2'b01};
        vecs[19] = '{1'b1, 1'b1 & 1'b0, 1'b1, 8'd1, 1'b1, 2'b11, 2'b10};

        reset     = 1'b1;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = 1'b0;
        cfg_div   = '0;
        valid3    = 1'b0;
        ch3       = 2'd3;
        div3      = '0;
        repeat (3) step();
        chk("reset tick", 32'(tick), 32'h0);
        chk("reset clk_out", 32'(clk_out), 32'h0);
        chk("reset ready", 32'(cfg_ready), 32'h1);

        // Release and run the table: ch1 gets div=1 while its cnt=2.
        step();
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            en        = vecs[k].en;
            cfg_valid = vecs[k].valid;
            cfg_ch    = vecs[k].ch;
            cfg_div   = vecs[k].div;
            valid3    = vecs[k].valid;
            #1;
            chk($sformatf("row%0d ready", k + 1), 32'(cfg_ready),
                32'(vecs[k].rdy));
            chk($sformatf("row%0d ready3", k + 1), 32'(ready3), 32'h1);
            sb_push($sformatf("row%0d", k + 1), vecs[k].tk, vecs[k].co);
            step();
            sb_pop_chk();
            chk($sformatf("row%0d tick3", k + 1), 32'(tick3),
                32'({3{vecs[k].tk[0]}}));
            chk($sformatf("row%0d clk3", k + 1), 32'(clk3),
                32'({3{vecs[k].co[0]}}));
        end
        cfg_valid = 1'b0;
        valid3    = 1'b0;

        // Freeze at cnt=3 for 7 cycles.
        repeat (3) step();
        held = clk_out;
        en   = 1'b0;
        for (int j = 0; j < 7; j++) begin
            sb_push($sformatf("en_low%0d", j), 2'b00, held);
            step();
            sb_pop_chk();
        end
        en = 1'b1;
        wait_tick(0, 10, n);
        chk("resume latency", n, 2);

        // Back-to-back writes to ch0.
        cfg_ch    = 1'b0;
        cfg_div   = 8'd2;
        cfg_valid = 1'b1;
        #1;
        chk("b2b first ready", 32'(cfg_ready), 32'h1);
        step();
        cfg_div = 8'd3;
        stalls  = 0;
        while (cfg_ready !== 1'b1 && stalls < 20) begin
            step();
            stalls++;
        end
        chk("b2b stall cycles", stalls, 4);
        step();
        cfg_valid = 1'b0;
        wait_tick(0, 10, n);
        chk("b2b div2 period", n, 2);
        wait_tick(0, 10, n);
        chk("b2b div3 period", n, 4);
        chk("b2b ready after", 32'(cfg_ready), 32'h1);

        // div=0 on ch1: continuous tick, clk_out at clk/2.
        cfg_ch    = 1'b1;
        cfg_div   = 8'd0;
        cfg_valid = 1'b1;
        #1;
        chk("div0 ready", 32'(cfg_ready), 32'h1);
        step();
        cfg_valid = 1'b0;
        wait_tick(1, 10, n);
        chk("div0 applied", 32'(tick[1]), 32'h1);
        c = clk_out[1];
        for (int j = 0; j < 4; j++) begin
            step();
            c = ~c;
            chk($sformatf("div0 tick%0d", j), 32'(tick[1]), 32'h1);
            chk($sformatf("div0 clk%0d", j), 32'(clk_out[1]), 32'(c));
        end

        // Asynchronous reset with a write still pending.
        cfg_ch    = 1'b0;
        cfg_div   = 8'd7;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        if (clk_out == 2'b00) step();
        #2;
        reset = 1'b1;
        #1;
        chk("async tick", 32'(tick), 32'h0);
        chk("async clk_out", 32'(clk_out), 32'h0);
        chk("async ready", 32'(cfg_ready), 32'h1);
        step();
        reset = 1'b0;
        wait_tick(0, 10, n);
        chk("post-reset first tick", n, 5);

`ifdef CLKDIV_SYNC_EN
        cfg_ch    = 1'b0;
        cfg_div   = 8'd2;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        wait_tick(0, 10, n);
        step();
        cfg_div   = 8'd4;
        cfg_valid = 1'b1;
        step();
        cfg_ch = 1'b1;
        step();
        cfg_valid = 1'b0;
        sync_clr  = 1'b1;
        step();
        sync_clr = 1'b0;
        chk("sync tick", 32'(tick), 32'h0);
        chk("sync clk_out", 32'(clk_out), 32'h0);
        chk("sync ready", 32'(cfg_ready), 32'h1);
        wait_tick(0, 10, n);
        chk("sync period", n, 5);
        chk("sync aligned", 32'(tick), 32'h3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
